tl_source_shrinker: RTL and testbench

Narrows the TileLink source-ID space between a host with many outstanding source IDs and a device that supports only a few, such as the FIFO-ordered device behind the size downsizer. On the first beat of each A-channel message it allocates a free narrow ID and records the original source in a table. On the last D-channel beat it restores the original source and frees the entry. It sits directly downstream of `tl_size_downsizer`, absorbing that block's widened `{source, offset}` IDs. It handles TL-UL/UH traffic only (channels A and D).

---
 rtl/tl_source_shrinker_pkg.sv | 39 +++
 rtl/tl_burst_tracker.sv | 63 ++++++
 rtl/tl_source_shrinker_checker.sv | 42 ++++
 rtl/tl_source_shrinker.sv | 248 ++++++++++++++++++++++++
 tb/tb_tl_source_shrinker.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_source_shrinker_pkg.sv
// Shared TileLink constants and beat-count helpers for the source shrinker slice.
package tl_source_shrinker_pkg;

    // A-channel opcodes used by the TL-UL/UH traffic this slice handles.
    localparam logic [2:0] TlPutFullData    = 3'd0;
    localparam logic [2:0] TlPutPartialData = 3'd1;
    localparam logic [2:0] TlGet            = 3'd4;

    // D-channel opcodes.
    localparam logic [2:0] TlAccessAck      = 3'd0;
    localparam logic [2:0] TlAccessAckData  = 3'd1;

    // A messages carry data for opcodes below Get. On D, the data-carrying
    // responses (AccessAckData, GrantData) are the ones with opcode bit 0 set.
    function automatic logic tl_has_data(input logic is_d_chan, input logic [2:0] opcode);
        logic result;
        if (is_d_chan) begin
            result = opcode[0];
        end else begin
            result = (opcode < 3'd4);
        end
        return result;
    endfunction

    // Number of beats in a message: a data-carrying message larger than one
    // beat spans 2**(size - beat_log2) beats, everything else is one beat.
    function automatic int unsigned tl_num_beats(input logic        has_data,
                                                 input int unsigned size,
                                                 input int unsigned beat_log2);
        int unsigned beats;
        if (has_data && (size > beat_log2)) begin
            beats = 32'd1 << (size - beat_log2);
        end else begin
            beats = 32'd1;
        end
        return beats;
    endfunction

endpackage

// File: rtl/tl_burst_tracker.sv
// Tracks beat position within TileLink messages on one channel and flags the
// first and last beat of each message.
module tl_burst_tracker
    import tl_source_shrinker_pkg::*;
#(
    parameter int DataWidth = 64,
    parameter int MaxSize   = 6,
    parameter int SizeWidth = 3,
    parameter bit IsDChan   = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    input  logic                 ready_i,
    input  logic [2:0]           opcode_i,
    input  logic [SizeWidth-1:0] size_i,
    output logic                 first_o,
    output logic                 last_o
);

    localparam int unsigned BeatLog2 = $clog2(DataWidth / 8);
    localparam int          CntWidth = MaxSize + 1;
    localparam logic [CntWidth-1:0] CntZero = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0] CntOne  = {{(CntWidth-1){1'b0}}, 1'b1};

    // Beats still owed by the message in flight; zero means the next beat is a first beat.
    logic [CntWidth-1:0] beats_left_q;
    logic [CntWidth-1:0] beats_left_d;
    logic [CntWidth-1:0] msg_beats;

    // Decode message length and advance the beat counter on each handshake.
    always_comb begin
        msg_beats = CntWidth'(tl_num_beats(tl_has_data(IsDChan, opcode_i),
                                           {{(32-SizeWidth){1'b0}}, size_i},
                                           BeatLog2));
        first_o   = (beats_left_q == CntZero);
        if (first_o) begin
            last_o = (msg_beats == CntOne);
        end else begin
            last_o = (beats_left_q == CntOne);
        end
        beats_left_d = beats_left_q;
        if (valid_i && ready_i) begin
            if (first_o) begin
                beats_left_d = msg_beats - CntOne;
            end else begin
                beats_left_d = beats_left_q - CntOne;
            end
        end else begin
            beats_left_d = beats_left_q;
        end
    end

    // Beat counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beats_left_q <= CntZero;
        end else begin
            beats_left_q <= beats_left_d;
        end
    end

endmodule

// File: rtl/tl_source_shrinker_checker.sv
// Simulation checks on the source shrinker ID table: no duplicate host source
// may be admitted, and no response may arrive for an unallocated device ID.
module tl_source_shrinker_checker #(
    parameter int HostSourceWidth   = 4,
    parameter int DeviceSourceWidth = 2,
    localparam int NumId = 32'd1 << DeviceSourceWidth
) (
    input logic                              clk_i,
    input logic                              rst_ni,
    input logic                              a_first_hs_i,
    input logic [HostSourceWidth-1:0]        a_source_i,
    input logic                              d_valid_i,
    input logic [DeviceSourceWidth-1:0]      d_source_i,
    input logic [NumId-1:0]                  valid_i,
    input logic [NumId*HostSourceWidth-1:0]  orig_i
);

    logic dup_source;
    logic d_stray;

    // Look for the incoming host source among live entries and for a response to a dead entry.
    always_comb begin
        dup_source = 1'b0;
        for (int i = 0; i < NumId; i++) begin
            if (valid_i[i] && (orig_i[i*HostSourceWidth +: HostSourceWidth] == a_source_i)) begin
                dup_source = 1'b1;
            end else begin
                dup_source = dup_source;
            end
        end
        d_stray = d_valid_i && !valid_i[d_source_i];
    end

    a_source_unique: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(a_first_hs_i && dup_source))
        else $error("tl_source_shrinker: host source %0d already outstanding", a_source_i);

    d_source_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !d_stray)
        else $error("tl_source_shrinker: D beat for unallocated device id %0d", d_source_i);

endmodule

// File: rtl/tl_source_shrinker.sv
// Narrows the TileLink source-ID space: allocates a small device ID on each A
// message, remembers the host source, and restores it on the D response.
module tl_source_shrinker
    import tl_source_shrinker_pkg::*;
#(
    parameter int AddrWidth         = 56,
    parameter int DataWidth         = 64,
    parameter int SinkWidth         = 1,
    parameter int HostSourceWidth   = 4,
    parameter int DeviceSourceWidth = 2,
    parameter int MaxSize           = 6,
    localparam int SizeWidth        = $clog2(MaxSize + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,

    // Host link (this block is the device)
    input  logic                         host_a_valid,
    output logic                         host_a_ready,
    input  logic [2:0]                   host_a_opcode,
    input  logic [2:0]                   host_a_param,
    input  logic [SizeWidth-1:0]         host_a_size,
    input  logic [HostSourceWidth-1:0]   host_a_source,
    input  logic [AddrWidth-1:0]         host_a_address,
    input  logic [DataWidth/8-1:0]       host_a_mask,
    input  logic [DataWidth-1:0]         host_a_data,
    input  logic                         host_a_corrupt,
    output logic                         host_b_valid,
    output logic                         host_c_ready,
    output logic                         host_d_valid,
    input  logic                         host_d_ready,
    output logic [2:0]                   host_d_opcode,
    output logic [1:0]                   host_d_param,
    output logic [SizeWidth-1:0]         host_d_size,
    output logic [HostSourceWidth-1:0]   host_d_source,
    output logic [SinkWidth-1:0]         host_d_sink,
    output logic                         host_d_denied,
    output logic [DataWidth-1:0]         host_d_data,
    output logic                         host_d_corrupt,
    output logic                         host_e_ready,

    // Device link (this block is the host)
    output logic                         device_a_valid,
    input  logic                         device_a_ready,
    output logic [2:0]                   device_a_opcode,
    output logic [2:0]                   device_a_param,
    output logic [SizeWidth-1:0]         device_a_size,
    output logic [DeviceSourceWidth-1:0] device_a_source,
    output logic [AddrWidth-1:0]         device_a_address,
    output logic [DataWidth/8-1:0]       device_a_mask,
    output logic [DataWidth-1:0]         device_a_data,
    output logic                         device_a_corrupt,
    output logic                         device_b_ready,
    output logic                         device_c_valid,
    input  logic                         device_d_valid,
    output logic                         device_d_ready,
    input  logic [2:0]                   device_d_opcode,
    input  logic [1:0]                   device_d_param,
    input  logic [SizeWidth-1:0]         device_d_size,
    input  logic [DeviceSourceWidth-1:0] device_d_source,
    input  logic [SinkWidth-1:0]         device_d_sink,
    input  logic                         device_d_denied,
    input  logic [DataWidth-1:0]         device_d_data,
    input  logic                         device_d_corrupt,
    output logic                         device_e_valid
);

    localparam int NumId = 32'd1 << DeviceSourceWidth;

    if (DeviceSourceWidth >= HostSourceWidth) begin : g_width_check
        $fatal(1, "tl_source_shrinker: DeviceSourceWidth must be narrower than HostSourceWidth");
    end

    typedef struct packed {
        logic                       valid;
        logic [HostSourceWidth-1:0] orig_source;
    } entry_t;

    // Lowest-index set bit of the free vector; only meaningful when any bit is set.
    function automatic logic [DeviceSourceWidth-1:0] lowest_free(input logic [NumId-1:0] free);
        logic [DeviceSourceWidth-1:0] idx;
        idx = {DeviceSourceWidth{1'b0}};
        for (int i = NumId - 1; i >= 0; i--) begin
            if (free[i]) begin
                idx = DeviceSourceWidth'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    entry_t                       entry_q [NumId];
    entry_t                       entry_d [NumId];
    logic [DeviceSourceWidth-1:0] cur_id_q;
    logic [DeviceSourceWidth-1:0] cur_id_d;

    logic [NumId-1:0]                 valid_vec;
    logic [NumId*HostSourceWidth-1:0] orig_flat;
    logic [NumId-1:0]                 free_vec;
    logic                             any_free;
    logic [DeviceSourceWidth-1:0]     alloc_id;
    logic                             a_first;
    logic                             a_last;
    logic                             d_first;
    logic                             d_last;
    logic                             a_hs;
    logic                             d_hs;
    logic                             unused_burst;

    // Burst position on the host A link; a_first gates allocation.
    tl_burst_tracker #(
        .DataWidth (DataWidth),
        .MaxSize   (MaxSize),
        .SizeWidth (SizeWidth),
        .IsDChan   (1'b0)
    ) u_a_tracker (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (host_a_valid),
        .ready_i  (host_a_ready),
        .opcode_i (host_a_opcode),
        .size_i   (host_a_size),
        .first_o  (a_first),
        .last_o   (a_last)
    );

    // Burst position on the device D link; d_last triggers the release.
    tl_burst_tracker #(
        .DataWidth (DataWidth),
        .MaxSize   (MaxSize),
        .SizeWidth (SizeWidth),
        .IsDChan   (1'b1)
    ) u_d_tracker (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (device_d_valid),
        .ready_i  (host_d_ready),
        .opcode_i (device_d_opcode),
        .size_i   (device_d_size),
        .first_o  (d_first),
        .last_o   (d_last)
    );

    assign unused_burst = a_last ^ d_first;

    // Flatten registered table state and pick the lowest free ID.
    always_comb begin
        valid_vec = {NumId{1'b0}};
        orig_flat = {(NumId*HostSourceWidth){1'b0}};
        for (int i = 0; i < NumId; i++) begin
            valid_vec[i] = entry_q[i].valid;
            orig_flat[i*HostSourceWidth +: HostSourceWidth] = entry_q[i].orig_source;
        end
        free_vec = ~valid_vec;
        any_free = |free_vec;
        alloc_id = lowest_free(free_vec);
    end

    // A channel: first beats wait for a free ID, later beats reuse the burst's ID.
    always_comb begin
        if (a_first) begin
            device_a_valid  = host_a_valid && any_free;
            host_a_ready    = device_a_ready && any_free;
            device_a_source = alloc_id;
        end else begin
            device_a_valid  = host_a_valid;
            host_a_ready    = device_a_ready;
            device_a_source = cur_id_q;
        end
    end

    assign device_a_opcode  = host_a_opcode;
    assign device_a_param   = host_a_param;
    assign device_a_size    = host_a_size;
    assign device_a_address = host_a_address;
    assign device_a_mask    = host_a_mask;
    assign device_a_data    = host_a_data;
    assign device_a_corrupt = host_a_corrupt;

    // D channel passes straight through with the original host source restored.
    assign host_d_valid   = device_d_valid;
    assign device_d_ready = host_d_ready;
    assign host_d_opcode  = device_d_opcode;
    assign host_d_param   = device_d_param;
    assign host_d_size    = device_d_size;
    assign host_d_source  = entry_q[device_d_source].orig_source;
    assign host_d_sink    = device_d_sink;
    assign host_d_denied  = device_d_denied;
    assign host_d_data    = device_d_data;
    assign host_d_corrupt = device_d_corrupt;

    assign host_b_valid   = 1'b0;
    assign host_c_ready   = 1'b1;
    assign host_e_ready   = 1'b1;
    assign device_b_ready = 1'b1;
    assign device_c_valid = 1'b0;
    assign device_e_valid = 1'b0;

    assign a_hs = host_a_valid && host_a_ready;
    assign d_hs = device_d_valid && host_d_ready;

    // Table update: allocation and release can land in the same cycle on distinct entries.
    always_comb begin
        entry_d  = entry_q;
        cur_id_d = cur_id_q;
        if (a_hs && a_first) begin
            entry_d[alloc_id].valid       = 1'b1;
            entry_d[alloc_id].orig_source = host_a_source;
            cur_id_d                      = alloc_id;
        end else begin
            cur_id_d = cur_id_q;
        end
        if (d_hs && d_last) begin
            entry_d[device_d_source].valid = 1'b0;
        end else begin
            cur_id_d = cur_id_d;
        end
    end

    // ID table and current-burst ID registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumId; i++) begin
                entry_q[i] <= '{valid: 1'b0, orig_source: {HostSourceWidth{1'b0}}};
            end
            cur_id_q <= {DeviceSourceWidth{1'b0}};
        end else begin
            entry_q  <= entry_d;
            cur_id_q <= cur_id_d;
        end
    end

    tl_source_shrinker_checker #(
        .HostSourceWidth   (HostSourceWidth),
        .DeviceSourceWidth (DeviceSourceWidth)
    ) u_checker (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .a_first_hs_i (a_hs && a_first),
        .a_source_i   (host_a_source),
        .d_valid_i    (device_d_valid),
        .d_source_i   (device_d_source),
        .valid_i      (valid_vec),
        .orig_i       (orig_flat)
    );

endmodule

// File: tb/tb_tl_source_shrinker.sv
// Self-checking bench for tl_source_shrinker: directed scenarios followed by a
// randomized traffic phase, all checked against a small ID-table model.
module tb_tl_source_shrinker;

    localparam int NUM_ID = 4;
    localparam logic [2:0] OP_PUTF = 3'd0;
    localparam logic [2:0] OP_PUTP = 3'd1;
    localparam logic [2:0] OP_GET  = 3'd4;
    localparam logic [2:0] OP_ACK  = 3'd0;
    localparam logic [2:0] OP_ACKD = 3'd1;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        host_a_valid, host_a_ready, host_a_corrupt;
    logic [2:0]  host_a_opcode, host_a_param, host_a_size;
    logic [3:0]  host_a_source;
    logic [55:0] host_a_address;
    logic [7:0]  host_a_mask;
    logic [63:0] host_a_data;
    logic        host_b_valid, host_c_ready, host_e_ready;
    logic        host_d_valid, host_d_ready, host_d_denied, host_d_corrupt;
    logic [2:0]  host_d_opcode, host_d_size;
    logic [1:0]  host_d_param;
    logic [3:0]  host_d_source;
    logic [0:0]  host_d_sink;
    logic [63:0] host_d_data;
    logic        device_a_valid, device_a_ready, device_a_corrupt;
    logic [2:0]  device_a_opcode, device_a_param, device_a_size;
    logic [1:0]  device_a_source;
    logic [55:0] device_a_address;
    logic [7:0]  device_a_mask;
    logic [63:0] device_a_data;
    logic        device_b_ready, device_c_valid, device_e_valid;
    logic        device_d_valid, device_d_ready, device_d_denied, device_d_corrupt;
    logic [2:0]  device_d_opcode, device_d_size;
    logic [1:0]  device_d_param;
    logic [1:0]  device_d_source;
    logic [0:0]  device_d_sink;
    logic [63:0] device_d_data;

    int tests = 0;
    int fails = 0;

    // Reference model: which device IDs are live, the host source behind each,
    // the request that opened it, and beats still owed on each link.
    bit         m_busy   [NUM_ID];
    logic [3:0] m_orig   [NUM_ID];
    logic [2:0] m_req_op [NUM_ID];
    logic [2:0] m_req_sz [NUM_ID];
    int         m_a_left;
    int         m_d_left;
    int         m_cur;

    tl_source_shrinker dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .host_a_valid     (host_a_valid),
        .host_a_ready     (host_a_ready),
        .host_a_opcode    (host_a_opcode),
        .host_a_param     (host_a_param),
        .host_a_size      (host_a_size),
        .host_a_source    (host_a_source),
        .host_a_address   (host_a_address),
        .host_a_mask      (host_a_mask),
        .host_a_data      (host_a_data),
        .host_a_corrupt   (host_a_corrupt),
        .host_b_valid     (host_b_valid),
        .host_c_ready     (host_c_ready),
        .host_d_valid     (host_d_valid),
        .host_d_ready     (host_d_ready),
        .host_d_opcode    (host_d_opcode),
        .host_d_param     (host_d_param),
        .host_d_size      (host_d_size),
        .host_d_source    (host_d_source),
        .host_d_sink      (host_d_sink),
        .host_d_denied    (host_d_denied),
        .host_d_data      (host_d_data),
        .host_d_corrupt   (host_d_corrupt),
        .host_e_ready     (host_e_ready),
        .device_a_valid   (device_a_valid),
        .device_a_ready   (device_a_ready),
        .device_a_opcode  (device_a_opcode),
        .device_a_param   (device_a_param),
        .device_a_size    (device_a_size),
        .device_a_source  (device_a_source),
        .device_a_address (device_a_address),
        .device_a_mask    (device_a_mask),
        .device_a_data    (device_a_data),
        .device_a_corrupt (device_a_corrupt),
        .device_b_ready   (device_b_ready),
        .device_c_valid   (device_c_valid),
        .device_d_valid   (device_d_valid),
        .device_d_ready   (device_d_ready),
        .device_d_opcode  (device_d_opcode),
        .device_d_param   (device_d_param),
        .device_d_size    (device_d_size),
        .device_d_source  (device_d_source),
        .device_d_sink    (device_d_sink),
        .device_d_denied  (device_d_denied),
        .device_d_data    (device_d_data),
        .device_d_corrupt (device_d_corrupt),
        .device_e_valid   (device_e_valid)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_lowest_free();
        for (int i = 0; i < NUM_ID; i++) begin
            if (!m_busy[i]) return i;
        end
        return -1;
    endfunction

    function automatic int m_beats(input bit is_d, input logic [2:0] op, input logic [2:0] sz);
        bit has_data;
        has_data = is_d ? (op == OP_ACKD || op == 3'd5) : (op < 3'd4);
        if (has_data && sz > 3'd3) return 1 << (int'(sz) - 3);
        return 1;
    endfunction

    function automatic logic [3:0] m_fresh_source();
        logic [3:0] s;
        bit clash;
        do begin
            s = 4'($urandom_range(0, 15));
            clash = 1'b0;
            for (int i = 0; i < NUM_ID; i++) begin
                if (m_busy[i] && m_orig[i] == s) clash = 1'b1;
            end
        end while (clash);
        return s;
    endfunction

    function automatic int m_count_busy();
        int n = 0;
        for (int i = 0; i < NUM_ID; i++) n += m_busy[i] ? 1 : 0;
        return n;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NUM_ID; i++) m_busy[i] = 1'b0;
        m_a_left = 0;
        m_d_left = 0;
        m_cur    = 0;
    endtask

    // One A beat, entered just after a rising edge; expects no stall.
    task automatic a_beat(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                          input logic [55:0] addr, input logic [63:0] data);
        int exp_id;
        exp_id = (m_a_left == 0) ? m_lowest_free() : m_cur;
        host_a_valid   = 1'b1;
        host_a_opcode  = op;
        host_a_size    = sz;
        host_a_source  = src;
        host_a_address = addr;
        host_a_data    = data;
        @(negedge clk_i);
        check("a_ready", host_a_ready, 1'b1);
        check("a_valid", device_a_valid, 1'b1);
        check("a_source", device_a_source, exp_id);
        check("a_addr", device_a_address, addr);
        check("a_data", device_a_data, data);
        @(posedge clk_i);
        if (m_a_left == 0) begin
            m_busy[exp_id]   = 1'b1;
            m_orig[exp_id]   = src;
            m_req_op[exp_id] = op;
            m_req_sz[exp_id] = sz;
            m_cur            = exp_id;
            m_a_left         = m_beats(1'b0, op, sz);
        end
        m_a_left--;
        #1;
        host_a_valid = 1'b0;
    endtask

    // One D beat for a live device ID, entered just after a rising edge.
    task automatic d_beat(input int id, input logic [2:0] op, input logic [2:0] sz, input logic [63:0] data);
        device_d_valid  = 1'b1;
        device_d_source = 2'(id);
        device_d_opcode = op;
        device_d_size   = sz;
        device_d_data   = data;
        host_d_ready    = 1'b1;
        @(negedge clk_i);
        check("d_valid", host_d_valid, 1'b1);
        check("d_ready", device_d_ready, 1'b1);
        check("d_source", host_d_source, m_orig[id]);
        check("d_opcode", host_d_opcode, op);
        check("d_data", host_d_data, data);
        @(posedge clk_i);
        if (m_d_left == 0) m_d_left = m_beats(1'b1, op, sz);
        m_d_left--;
        if (m_d_left == 0) m_busy[id] = 1'b0;
        #1;
        device_d_valid = 1'b0;
    endtask

    task automatic send_a(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src);
        logic [55:0] addr;
        int n;
        addr = {$urandom, $urandom};
        n = m_beats(1'b0, op, sz);
        for (int b = 0; b < n; b++) a_beat(op, sz, src, addr, {$urandom, $urandom});
    endtask

    task automatic respond(input int id);
        logic [2:0] op;
        logic [2:0] sz;
        int n;
        if (m_req_op[id] == OP_GET) begin
            op = OP_ACKD;
            sz = m_req_sz[id];
        end else begin
            op = OP_ACK;
            sz = 3'($urandom_range(0, 3));
        end
        n = m_beats(1'b1, op, sz);
        for (int b = 0; b < n; b++) d_beat(id, op, sz, {$urandom, $urandom});
    endtask

    initial begin
        int q_ids[$];
        logic [2:0] op;
        m_clear();
        rst_ni = 1'b0;
        host_a_valid = 1'b0; host_a_opcode = OP_GET; host_a_param = 3'd0; host_a_size = 3'd0;
        host_a_source = 4'd0; host_a_address = 56'd0; host_a_mask = 8'hFF; host_a_data = 64'd0;
        host_a_corrupt = 1'b0; host_d_ready = 1'b1; device_a_ready = 1'b1;
        device_d_valid = 1'b0; device_d_opcode = OP_ACK; device_d_param = 2'd0; device_d_size = 3'd0;
        device_d_source = 2'd0; device_d_sink = 1'b0; device_d_denied = 1'b0; device_d_data = 64'd0;
        device_d_corrupt = 1'b0;

        // Reset state and tied-off channels
        @(negedge clk_i);
        check("rst_dev_a_valid", device_a_valid, 1'b0);
        check("rst_host_d_valid", host_d_valid, 1'b0);
        check("rst_host_a_ready", host_a_ready, 1'b1);
        check("tie_host_b_valid", host_b_valid, 1'b0);
        check("tie_host_c_ready", host_c_ready, 1'b1);
        check("tie_host_e_ready", host_e_ready, 1'b1);
        check("tie_dev_b_ready", device_b_ready, 1'b1);
        check("tie_dev_c_valid", device_c_valid, 1'b0);
        check("tie_dev_e_valid", device_e_valid, 1'b0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Backpressure from the device reaches the host unchanged
        device_a_ready = 1'b0;
        host_a_valid = 1'b1; host_a_opcode = OP_GET; host_a_size = 3'd2; host_a_source = 4'd9;
        @(negedge clk_i);
        check("bp_host_a_ready", host_a_ready, 1'b0);
        check("bp_dev_a_valid", device_a_valid, 1'b1);
        @(posedge clk_i); #1;
        device_a_ready = 1'b1;
        host_a_valid = 1'b0;

        // Single Get, source 9, round trip, then the ID is reusable
        send_a(OP_GET, 3'd3, 4'd9);
        check("single_id0", m_cur, 0);
        respond(0);
        send_a(OP_GET, 3'd2, 4'd9);
        respond(0);

        // Fill the table, stall a fifth Get, release ID 2
        send_a(OP_GET, 3'd2, 4'd1);
        send_a(OP_GET, 3'd2, 4'd2);
        send_a(OP_GET, 3'd2, 4'd3);
        send_a(OP_GET, 3'd2, 4'd4);
        host_a_valid = 1'b1; host_a_opcode = OP_GET; host_a_size = 3'd2; host_a_source = 4'd5;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            check("full_host_a_ready", host_a_ready, 1'b0);
            check("full_dev_a_valid", device_a_valid, 1'b0);
            @(posedge clk_i); #1;
        end
        device_d_valid = 1'b1; device_d_source = 2'd2; device_d_opcode = OP_ACKD; device_d_size = 3'd2;
        @(negedge clk_i);
        check("full_d_source", host_d_source, 4'd3);
        check("full_ready_same_cycle", host_a_ready, 1'b0);
        @(posedge clk_i);
        m_busy[2] = 1'b0;
        #1;
        device_d_valid = 1'b0;
        @(negedge clk_i);
        check("freed_host_a_ready", host_a_ready, 1'b1);
        check("freed_id", device_a_source, m_lowest_free());
        @(posedge clk_i);
        m_busy[2] = 1'b1; m_orig[2] = 4'd5; m_req_op[2] = OP_GET; m_req_sz[2] = 3'd2; m_cur = 2;
        #1;
        host_a_valid = 1'b0;
        // Out-of-order completions
        respond(3);
        respond(0);
        respond(1);
        respond(2);

        // 8-beat PutFullData that fills the table on its first beat
        send_a(OP_GET, 3'd2, 4'd1);
        send_a(OP_GET, 3'd2, 4'd2);
        send_a(OP_GET, 3'd2, 4'd3);
        send_a(OP_PUTF, 3'd6, 4'd7);
        respond(3);
        respond(0);
        respond(1);
        respond(2);

        // 8-beat AccessAckData holds its entry until the last beat
        send_a(OP_GET, 3'd6, 4'd11);
        for (int b = 0; b < 7; b++) d_beat(0, OP_ACKD, 3'd6, {$urandom, $urandom});
        send_a(OP_GET, 3'd2, 4'd12);
        d_beat(0, OP_ACKD, 3'd6, {$urandom, $urandom});
        send_a(OP_GET, 3'd2, 4'd13);
        respond(0);
        respond(1);

        // Allocation and release in the same cycle both take effect
        send_a(OP_GET, 3'd2, 4'd1);
        send_a(OP_GET, 3'd2, 4'd2);
        host_a_valid = 1'b1; host_a_opcode = OP_GET; host_a_size = 3'd2; host_a_source = 4'd14;
        device_d_valid = 1'b1; device_d_source = 2'd0; device_d_opcode = OP_ACKD; device_d_size = 3'd2;
        @(negedge clk_i);
        check("same_cycle_a_source", device_a_source, m_lowest_free());
        check("same_cycle_d_source", host_d_source, m_orig[0]);
        @(posedge clk_i);
        m_busy[2] = 1'b1; m_orig[2] = 4'd14; m_req_op[2] = OP_GET; m_req_sz[2] = 3'd2; m_cur = 2;
        m_busy[0] = 1'b0;
        #1;
        host_a_valid = 1'b0;
        device_d_valid = 1'b0;
        send_a(OP_GET, 3'd2, 4'd15);
        send_a(OP_GET, 3'd2, 4'd3);
        for (int i = 0; i < NUM_ID; i++) respond(i);

        // Reset in the middle of a write burst
        a_beat(OP_PUTF, 3'd6, 4'd8, 56'h1000, 64'h1);
        a_beat(OP_PUTF, 3'd6, 4'd8, 56'h1000, 64'h2);
        a_beat(OP_PUTF, 3'd6, 4'd8, 56'h1000, 64'h3);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("midrst_dev_a_valid", device_a_valid, 1'b0);
        check("midrst_host_a_ready", host_a_ready, 1'b1);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        m_clear();
        send_a(OP_GET, 3'd2, 4'd6);
        check("postrst_id0", m_cur, 0);
        respond(0);

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            int nb;
            nb = m_count_busy();
            if (nb < NUM_ID && (nb == 0 || $urandom_range(0, 1) == 0)) begin
                case ($urandom_range(0, 2))
                    0: op = OP_GET;
                    1: op = OP_PUTF;
                    default: op = OP_PUTP;
                endcase
                send_a(op, 3'($urandom_range(0, 6)), m_fresh_source());
            end else begin
                q_ids.delete();
                for (int i = 0; i < NUM_ID; i++) if (m_busy[i]) q_ids.push_back(i);
                respond(q_ids[$urandom_range(0, q_ids.size() - 1)]);
            end
        end
        for (int i = 0; i < NUM_ID; i++) if (m_busy[i]) respond(i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
